trig_capture: RTL and testbench

Samples the comparator `trigger` against the free-running frame counter and frame reset produced by the upstream frame-timing stage. Each frame, it records the counter value at the first trigger edge and averages over 2^AVG_LOG2 frames. Completed averages go out on a valid/ready interface, and a frame-aligned PWM output is driven from the latest average. It sits directly downstream of the frame counter and is the digital back end of the analog ramp/comparator loop.

---
 rtl/trig_capture.sv | 136 +++++++++++++
 tb/tb_trig_capture.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/trig_capture.sv
// Captures the first synchronised trigger edge per frame, averages it over 2^AVG_LOG2
// frames and offers the result on valid/ready, while also driving a frame-aligned PWM.
module trig_capture #(
  parameter int CNT_W       = 8,
  parameter int AVG_LOG2    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [CNT_W-1:0] counter,
  input  logic             frame_rst,
  input  logic             trigger,
  input  logic             sample_ready,
  output logic [CNT_W-1:0] sample,
  output logic             sample_valid,
  output logic             pwm_out,
  output logic             no_trig,
  output logic             overrun
);
  localparam int ACC_W  = CNT_W + AVG_LOG2;
  localparam int FCNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0]  CAP_NONE  = '1;
  localparam logic [CNT_W-1:0]  SYNC_COMP = CNT_W'(SYNC_STAGES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ARMED, S_DONE} state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   trig_prev_q;
  logic                   frst_q;
  logic [CNT_W-1:0]       cap_q;
  logic [ACC_W-1:0]       acc_q;
  logic [FCNT_W-1:0]      fcnt_q;
  logic [CNT_W-1:0]       duty_q;
  logic [CNT_W-1:0]       duty_active_q;
  logic [CNT_W-1:0]       sample_q;
  logic                   sample_valid_q;
  logic                   pwm_q;
  logic                   no_trig_q;
  logic                   overrun_q;

  logic             trig_edge;
  logic             frst_rise;
  logic             frst_fall;
  logic             close;
  logic             avg_vld;
  logic [CNT_W-1:0] cap_now;
  logic [CNT_W-1:0] cap_close;
  logic [CNT_W-1:0] duty_eff;
  logic [CNT_W-1:0] avg_d;
  logic [ACC_W-1:0] acc_d;

  always_comb begin
    trig_edge = sync_q[SYNC_STAGES-1] & ~trig_prev_q;
    frst_rise = frame_rst & ~frst_q;
    frst_fall = ~frame_rst & frst_q;
    close     = frst_rise && ((state_q == S_ARMED) || (state_q == S_DONE));
    // Undo the synchroniser delay so cap reflects the counter at the trigger rise.
    cap_now   = (counter >= SYNC_COMP) ? (counter - SYNC_COMP) : '0;
    // A frame still ARMED at the boundary closes as "no trigger", even if an edge lands now.
    cap_close = (state_q == S_DONE) ? cap_q : CAP_NONE;
    acc_d     = acc_q + ACC_W'(cap_close);
    avg_vld   = close && (fcnt_q == FCNT_LAST);
    avg_d     = CNT_W'(acc_d >> AVG_LOG2);
    // The new duty must already apply in the first window cycle of the frame.
    duty_eff  = frst_fall ? duty_q : duty_active_q;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= S_IDLE;
      sync_q         <= '0;
      trig_prev_q    <= 1'b0;
      frst_q         <= 1'b0;
      cap_q          <= '0;
      acc_q          <= '0;
      fcnt_q         <= '0;
      duty_q         <= '0;
      duty_active_q  <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      pwm_q          <= 1'b0;
      no_trig_q      <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], trigger};
      trig_prev_q <= sync_q[SYNC_STAGES-1];
      frst_q      <= frame_rst;
      no_trig_q   <= 1'b0;

      case (state_q)
        S_IDLE:  if (frame_rst) state_q <= S_WAIT;
        S_WAIT:  if (frst_fall) state_q <= S_ARMED;
        S_ARMED: begin
          if (frst_rise) begin
            cap_q     <= CAP_NONE;
            no_trig_q <= 1'b1;
            state_q   <= S_WAIT;
          end else if (trig_edge && !frame_rst) begin
            cap_q   <= cap_now;
            state_q <= S_DONE;
          end
        end
        S_DONE:  if (frst_rise) state_q <= S_WAIT;
        default: state_q <= S_IDLE;
      endcase

      if (close) begin
        acc_q  <= avg_vld ? '0 : acc_d;
        fcnt_q <= avg_vld ? '0 : fcnt_q + 1'b1;
      end

      if (avg_vld) begin
        duty_q <= avg_d;
        if (!sample_valid_q || sample_ready) begin
          sample_q       <= avg_d;
          sample_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (sample_valid_q && sample_ready) begin
        sample_valid_q <= 1'b0;
      end

      if (frst_fall) duty_active_q <= duty_q;
      pwm_q <= !frame_rst && (counter < duty_eff);
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign pwm_out      = pwm_q;
  assign no_trig      = no_trig_q;
  assign overrun      = overrun_q;
endmodule

// File: tb/tb_trig_capture.sv
// Directed bench for trig_capture: a frame generator drives counter/frame_rst/trigger,
// expected averages go into a queue and are popped when the DUT transfers a sample.
module tb_trig_capture;
  localparam int CNT_W = 8;
  localparam int AVG_LOG2 = 2;
  localparam int SYNC = 2;
  localparam int WIN = 200;
  localparam int GAP = 4;

  logic             clk;
  logic             n_rst;
  logic [CNT_W-1:0] counter;
  logic             frame_rst;
  logic             trigger;
  logic             sample_ready;
  logic [CNT_W-1:0] sample;
  logic             sample_valid;
  logic             pwm_out;
  logic             no_trig;
  logic             overrun;

  trig_capture #(.CNT_W(CNT_W), .AVG_LOG2(AVG_LOG2), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .n_rst(n_rst), .counter(counter), .frame_rst(frame_rst),
    .trigger(trigger), .sample_ready(sample_ready), .sample(sample),
    .sample_valid(sample_valid), .pwm_out(pwm_out), .no_trig(no_trig),
    .overrun(overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int pwm_total = 0;

  // Reference model state
  int exp_acc = 0;
  int exp_fcnt = 0;
  int exp_duty = 0;
  int exp_duty_act = 0;
  int exp_held = 0;
  bit exp_overrun = 1'b0;
  bit slot_full = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (pwm_out) pwm_total++;
  end

  always @(negedge clk) begin
    int e;
    if (n_rst && sample_valid && sample_ready) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      check("sample_transfer", {24'd0, sample}, e);
    end
  end

  task automatic drive_cycle(input int cnt, input bit frst, input bit trig);
    @(posedge clk);
    #1;
    counter   = CNT_W'(cnt);
    frame_rst = frst;
    trigger   = trig;
  endtask

  function automatic bit pulse(input int c, input int t);
    return (t >= 0) && (c >= t) && (c < t + 3);
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // One measurement window plus the following frame-reset gap; t1<0 means no trigger.
  task automatic run_frame(input int t1, input int t2, input bit late);
    int p0;
    int cap;
    int avg;
    bit wrap;
    p0 = 0;
    exp_duty_act = exp_duty;
    for (int c = 0; c < WIN; c++) begin
      drive_cycle(c, 1'b0, pulse(c, t1) || pulse(c, t2) || (late && c >= WIN - SYNC));
      if (c == 0) p0 = pwm_total;
    end
    cap = (t1 >= 0) ? t1 : 255;
    exp_acc += cap;
    wrap = (exp_fcnt == (1 << AVG_LOG2) - 1);
    exp_fcnt = wrap ? 0 : exp_fcnt + 1;
    if (wrap) begin
      avg = exp_acc >> AVG_LOG2;
      exp_acc = 0;
      exp_duty = avg;
      if (sample_ready) exp_q.push_back(avg);
      else if (!slot_full) begin
        exp_q.push_back(avg);
        slot_full = 1'b1;
        exp_held = avg;
      end else exp_overrun = 1'b1;
    end
    for (int g = 0; g < GAP; g++) begin
      drive_cycle(0, 1'b1, 1'b0);
      if (g == 1) begin
        check("pwm_high_cycles", pwm_total - p0, min_i(exp_duty_act, WIN));
        @(negedge clk);
        check("no_trig_pulse", {31'd0, no_trig}, {31'd0, t1 < 0});
        check("valid_after_close", {31'd0, sample_valid}, {31'd0, (wrap && sample_ready) || slot_full});
      end else if (g == 2) begin
        @(negedge clk);
        check("no_trig_single", {31'd0, no_trig}, 0);
        check("valid_settled", {31'd0, sample_valid}, {31'd0, slot_full});
        check("overrun", {31'd0, overrun}, {31'd0, exp_overrun});
        if (slot_full) check("sample_held", {24'd0, sample}, exp_held);
      end
    end
  endtask

  initial begin
    int p0;
    n_rst = 1'b0;
    counter = '0;
    frame_rst = 1'b0;
    trigger = 1'b0;
    sample_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sample", {24'd0, sample}, 0);
    check("rst_valid", {31'd0, sample_valid}, 0);
    check("rst_pwm", {31'd0, pwm_out}, 0);
    check("rst_no_trig", {31'd0, no_trig}, 0);
    check("rst_overrun", {31'd0, overrun}, 0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    for (int g = 0; g < GAP; g++) drive_cycle(0, 1'b1, 1'b0);

    // Steady trigger at 100
    for (int f = 0; f < 8; f++) run_frame(100, -1, 1'b0);
    // No trigger for 4 frames
    for (int f = 0; f < 4; f++) run_frame(-1, -1, 1'b0);
    // Varied positions
    run_frame(10, -1, 1'b0);
    run_frame(20, -1, 1'b0);
    run_frame(30, -1, 1'b0);
    run_frame(41, -1, 1'b0);
    // Multiple edges, then an edge coincident with the frame boundary
    run_frame(50, 120, 1'b0);
    run_frame(-1, -1, 1'b1);
    run_frame(30, -1, 1'b0);
    run_frame(30, -1, 1'b0);
    // Backpressure for 8 frames
    sample_ready = 1'b0;
    for (int f = 0; f < 8; f++) run_frame(60, -1, 1'b0);
    @(posedge clk);
    #1;
    sample_ready = 1'b1;
    slot_full = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("valid_after_drain", {31'd0, sample_valid}, 0);
    check("overrun_sticky", {31'd0, overrun}, 1);
    check("queue_after_drain", exp_q.size(), 0);

    // Reset mid-frame at counter 80
    for (int c = 0; c <= 80; c++) drive_cycle(c, 1'b0, 1'b0);
    n_rst = 1'b0;
    #1;
    check("midrst_sample", {24'd0, sample}, 0);
    check("midrst_valid", {31'd0, sample_valid}, 0);
    check("midrst_pwm", {31'd0, pwm_out}, 0);
    check("midrst_no_trig", {31'd0, no_trig}, 0);
    check("midrst_overrun", {31'd0, overrun}, 0);
    exp_acc = 0;
    exp_fcnt = 0;
    exp_duty = 0;
    exp_duty_act = 0;
    exp_overrun = 1'b0;
    slot_full = 1'b0;
    p0 = 0;
    for (int c = 81; c < WIN; c++) begin
      drive_cycle(c, 1'b0, pulse(c, 120));
      if (c == 81) begin
        n_rst = 1'b1;
        p0 = pwm_total;
      end
    end
    for (int g = 0; g < GAP; g++) begin
      drive_cycle(0, 1'b1, 1'b0);
      if (g == 1) begin
        check("partial_pwm", pwm_total - p0, 0);
        @(negedge clk);
        check("partial_no_trig", {31'd0, no_trig}, 0);
        check("partial_valid", {31'd0, sample_valid}, 0);
      end
    end
    for (int f = 0; f < 5; f++) run_frame(77, -1, 1'b0);

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
